// File: rtl/mux_dispatch_ctrl.sv
// Result-code sequencer: buffers codes in a small FIFO and issues them to the routing mux when the target channel is ready.
// Optional per-class dispatch counters are built only when DISPATCH_COUNT_EN is defined.
module mux_dispatch_ctrl #(
    parameter int SIZE  = 5,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [SIZE-1:0]  in_res,
    output logic             in_ready,
    input  logic             ch1_ready,
    input  logic             ch2_ready,
    output logic [SIZE-1:0]  mux_res,
    output logic             mux_en,
    output logic             dispatched,
    output logic [CNT_W-1:0] cnt_one,
    output logic [CNT_W-1:0] cnt_three,
    output logic [CNT_W-1:0] cnt_other
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    state_t state, next_state;

    logic [SIZE-1:0] mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [SIZE-1:0] hold;
    logic            push;
    logic            pop;
    logic            tr;

    // in_ready comes from the registered count, so a full FIFO refuses a push even in its pop cycle
    assign in_ready = (count != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (state == IDLE) && (count != '0);
    assign mux_res  = hold;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold <= '0;
        end else if (pop) begin
            hold <= mem[rd_ptr];
        end
    end

    always_comb begin
        tr = 1'b1;
        if (hold == SIZE'(1)) begin
            tr = ch1_ready;
        end else if (hold == SIZE'(3)) begin
            tr = ch2_ready;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (count != '0) next_state = HOLD;
            HOLD:    if (tr) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        mux_en     = 1'b0;
        dispatched = 1'b0;
        if (state == HOLD && tr) begin
            mux_en     = 1'b1;
            dispatched = 1'b1;
        end
    end

`ifdef DISPATCH_COUNT_EN
    // Counters wrap naturally at 2^CNT_W
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_one   <= '0;
            cnt_three <= '0;
            cnt_other <= '0;
        end else if (dispatched) begin
            if (hold == SIZE'(1)) begin
                cnt_one <= cnt_one + CNT_W'(1);
            end else if (hold == SIZE'(3)) begin
                cnt_three <= cnt_three + CNT_W'(1);
            end else begin
                cnt_other <= cnt_other + CNT_W'(1);
            end
        end
    end
`else
    assign cnt_one   = '0;
    assign cnt_three = '0;
    assign cnt_other = '0;
`endif

endmodule

// File: tb/tb_mux_dispatch_ctrl.sv
// Bench for mux_dispatch_ctrl: queue-based reference model checked every cycle, directed scenarios, then random traffic.
// Counter expectations follow DISPATCH_COUNT_EN when the bench is compiled with it.
module tb_mux_dispatch_ctrl;

    localparam int SIZE  = 5;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

`ifdef DISPATCH_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [SIZE-1:0]  in_res = '0;
    logic             in_ready;
    logic             ch1_ready = 1'b0;
    logic             ch2_ready = 1'b0;
    logic [SIZE-1:0]  mux_res;
    logic             mux_en;
    logic             dispatched;
    logic [CNT_W-1:0] cnt_one;
    logic [CNT_W-1:0] cnt_three;
    logic [CNT_W-1:0] cnt_other;

    mux_dispatch_ctrl #(.SIZE(SIZE), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_res(in_res),
        .in_ready(in_ready),
        .ch1_ready(ch1_ready),
        .ch2_ready(ch2_ready),
        .mux_res(mux_res),
        .mux_en(mux_en),
        .dispatched(dispatched),
        .cnt_one(cnt_one),
        .cnt_three(cnt_three),
        .cnt_other(cnt_other)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // Reference model: a FIFO queue, one held code with a "waiting" flag, and per-class tallies
    int q[$];
    int held = 0;
    bit held_valid = 1'b0;
    int m_one = 0, m_three = 0, m_other = 0;
    bit model_on = 1'b0;
    int log_codes[$];

    function automatic bit target_ready(input int code);
        if (code == 1) return ch1_ready;
        if (code == 3) return ch2_ready;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit issue;
        bit accept;
        if (rst) begin
            q.delete();
            held       = 0;
            held_valid = 1'b0;
            m_one      = 0;
            m_three    = 0;
            m_other    = 0;
            model_on   = 1'b1;
        end else begin
            issue  = held_valid && target_ready(held);
            accept = in_valid && (q.size() < DEPTH);
            if (issue) begin
                held_valid = 1'b0;
                if (held == 1) m_one++;
                else if (held == 3) m_three++;
                else m_other++;
            end else if (!held_valid && q.size() > 0) begin
                held       = q.pop_front();
                held_valid = 1'b1;
            end
            if (accept) q.push_back(int'(in_res));
        end
    end

    always @(negedge clk) begin
        bit exp_en;
        if (model_on) begin
            exp_en = held_valid && target_ready(held);
            check_val("in_ready", int'(in_ready), int'(q.size() < DEPTH));
            check_val("mux_res", int'(mux_res), held);
            check_val("mux_en", int'(mux_en), int'(exp_en));
            check_val("dispatched", int'(dispatched), int'(exp_en));
            check_val("cnt_one", int'(cnt_one), CNT_ON ? (m_one % 256) : 0);
            check_val("cnt_three", int'(cnt_three), CNT_ON ? (m_three % 256) : 0);
            check_val("cnt_other", int'(cnt_other), CNT_ON ? (m_other % 256) : 0);
            if (dispatched) log_codes.push_back(int'(mux_res));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Offer one code and keep it on the bus until the DUT takes it
    task automatic apply_stimulus(input int code);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_res   = SIZE'(code);
        while (!in_ready && waited < 60) begin
            step();
            waited++;
        end
        if (waited >= 60) report_timeout("push_wait");
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_log(input int target, input int limit);
        int n;
        n = 0;
        while (log_codes.size() < target && n < limit) begin
            step();
            n++;
        end
        if (log_codes.size() < target) report_timeout("dispatch_wait");
    endtask

    task automatic check_output(input string name, input int exp_en, input int exp_res);
        check_val({name, "_en"}, int'(mux_en), exp_en);
        check_val({name, "_disp"}, int'(dispatched), exp_en);
        check_val({name, "_res"}, int'(mux_res), exp_res);
    endtask

    initial begin
        int order3[5];
        int order4[6];
        int r;
        order3 = '{1, 3, 7, 0, 9};
        order4 = '{1, 5, 6, 8, 10, 11};

        step();
        step();
        rst = 1'b0;
        check_val("rst_in_ready", int'(in_ready), 1);
        check_output("rst", 0, 0);
        check_val("rst_cnt_one", int'(cnt_one), 0);

        // Latency: push at edge N, enable in the cycle after edge N+1
        ch1_ready = 1'b1;
        apply_stimulus(1);
        check_val("lat_n_en", int'(mux_en), 0);
        step();
        check_output("lat_n1", 1, 1);
        step();
        check_val("lat_after_en", int'(mux_en), 0);
        check_val("lat_cnt_one", int'(cnt_one), CNT_ON ? 1 : 0);

        // Stalled channel 2 for five cycles
        ch2_ready = 1'b0;
        apply_stimulus(3);
        step();
        for (int i = 0; i < 5; i++) begin
            check_output("stall3", 0, 3);
            step();
        end
        ch2_ready = 1'b1;
        #1;
        check_output("release3", 1, 3);
        step();
        check_val("cnt_three", int'(cnt_three), CNT_ON ? 1 : 0);

        // Fill while both consumers stall; order must survive
        ch1_ready = 1'b0;
        ch2_ready = 1'b0;
        log_codes.delete();
        foreach (order3[i]) apply_stimulus(order3[i]);
        check_val("fill_in_ready", int'(in_ready), 0);
        check_output("fill_hold", 0, 1);
        ch1_ready = 1'b1;
        ch2_ready = 1'b1;
        wait_log(5, 100);
        for (int i = 0; i < 5; i++) begin
            check_val("order3", (i < log_codes.size()) ? log_codes[i] : -1, order3[i]);
        end
        step();
        check_val("cnt_other3", int'(cnt_other), CNT_ON ? 3 : 0);

        // Push attempted while full in the cycle the FIFO pops
        ch1_ready = 1'b0;
        log_codes.delete();
        for (int i = 0; i < 5; i++) apply_stimulus(order4[i]);
        in_valid = 1'b1;
        in_res   = SIZE'(11);
        check_val("full_in_ready", int'(in_ready), 0);
        ch1_ready = 1'b1;
        #1;
        check_output("full_disp", 1, 1);
        step();
        check_val("popcycle_in_ready", int'(in_ready), 0);
        check_val("popcycle_en", int'(mux_en), 0);
        step();
        check_val("after_pop_in_ready", int'(in_ready), 1);
        check_val("after_pop_res", int'(mux_res), 5);
        step();
        in_valid = 1'b0;
        wait_log(6, 100);
        for (int i = 0; i < 6; i++) begin
            check_val("order4", (i < log_codes.size()) ? log_codes[i] : -1, order4[i]);
        end
        check_val("order4_len", log_codes.size(), 6);

        // Reset while holding with three codes queued
        ch1_ready = 1'b0;
        foreach (order3[i]) if (i < 4) apply_stimulus((i == 0) ? 1 : 2 * i);
        log_codes.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_output("midrst", 0, 0);
        check_val("midrst_in_ready", int'(in_ready), 1);
        check_val("midrst_cnt_other", int'(cnt_other), 0);
        ch1_ready = 1'b1;
        ch2_ready = 1'b1;
        repeat (10) step();
        check_val("midrst_no_disp", log_codes.size(), 0);

        // Counter wrap on 257 "other" codes
        for (int i = 0; i < 257; i++) apply_stimulus(2);
        wait_log(257, 200);
        step();
        check_val("wrap_cnt_other", int'(cnt_other), CNT_ON ? 1 : 0);
        check_val("wrap_cnt_one", int'(cnt_one), 0);

        // Random traffic with occasional reset
        for (int c = 0; c < 3000; c++) begin
            r         = int'($urandom_range(0, 3));
            in_valid  = 1'($urandom_range(0, 1));
            in_res    = (r == 0) ? SIZE'(1) : (r == 1) ? SIZE'(3) : SIZE'($urandom_range(0, 31));
            ch1_ready = ($urandom_range(0, 3) != 0);
            ch2_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        step();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
